out2in_rr_arbiter: RTL and testbench

//  Two-requester round-robin arbiter that shares one PipeIn sink between two PipeOut sources.

---
 rtl/out2in_rr_arbiter_if.sv | 35 +++
 rtl/out2in_rr_arbiter.sv | 107 ++++++++++
 tb/tb_out2in_rr_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/out2in_rr_arbiter_if.sv
// Handshake bundle between the two PipeOut sources, the PipeIn sink and the
// round-robin arbiter. The arbiter uses the master modport; the environment uses slave.
interface out2in_rr_arbiter_if #(
  parameter int width = 32
);
  logic [width-1:0] in0_first;
  logic             in0_first__RDY;
  logic             in0_deq__RDY;
  logic             in0_deq__ENA;
  logic [width-1:0] in1_first;
  logic             in1_first__RDY;
  logic             in1_deq__RDY;
  logic             in1_deq__ENA;
  logic             out_enq__RDY;
  logic             out_enq__ENA;
  logic [width-1:0] out_enq_v;
  logic             grant_valid;
  logic             grant_idx;

  modport master (
    input  in0_first, in0_first__RDY, in0_deq__RDY,
    input  in1_first, in1_first__RDY, in1_deq__RDY,
    input  out_enq__RDY,
    output in0_deq__ENA, in1_deq__ENA, out_enq__ENA, out_enq_v,
    output grant_valid, grant_idx
  );

  modport slave (
    output in0_first, in0_first__RDY, in0_deq__RDY,
    output in1_first, in1_first__RDY, in1_deq__RDY,
    output out_enq__RDY,
    input  in0_deq__ENA, in1_deq__ENA, out_enq__ENA, out_enq_v,
    input  grant_valid, grant_idx
  );
endinterface

// File: rtl/out2in_rr_arbiter.sv
// Two-source round-robin burst arbiter feeding one sink through a 1-entry
// registered output buffer; re-arbitrates after MAX_BURST beats or when the granted source runs dry.
module out2in_rr_arbiter #(
  parameter int width     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                CLK,
  input  logic                RST,
  out2in_rr_arbiter_if.master bus
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             grant_idx_q, grant_idx_d;
  logic             obuf_valid_q, obuf_valid_d;
  logic [width-1:0] obuf_data_q, obuf_data_d;

  logic          v0, v1, vg, winner, accept, out_ena, take, sel;
  logic [CW-1:0] cnt_inc;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      grant_idx_q  <= 1'b0;
      obuf_valid_q <= 1'b0;
      obuf_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      grant_idx_q  <= grant_idx_d;
      obuf_valid_q <= obuf_valid_d;
      obuf_data_q  <= obuf_data_d;
    end
  end

  // Output / handshake decode
  always_comb begin
    v0      = bus.in0_first__RDY && bus.in0_deq__RDY;
    v1      = bus.in1_first__RDY && bus.in1_deq__RDY;
    vg      = grant_idx_q ? v1 : v0;
    out_ena = obuf_valid_q && bus.out_enq__RDY && !RST;
    accept  = !obuf_valid_q || out_ena;
    winner  = (v0 && v1) ? !last_q : v1;
    sel     = grant_idx_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        sel  = winner;
        take = (v0 || v1) && accept;
      end
      BURST: begin
        sel  = grant_idx_q;
        take = vg && accept;
      end
      default: ;
    endcase
  end

  assign bus.in0_deq__ENA = take && !sel && !RST;
  assign bus.in1_deq__ENA = take && sel && !RST;
  assign bus.out_enq__ENA = out_ena;
  assign bus.out_enq_v    = obuf_data_q;
  assign bus.grant_valid  = (state_q == BURST) && !RST;
  assign bus.grant_idx    = grant_idx_q;

  // Next-state and buffer update
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    grant_idx_d  = grant_idx_q;
    cnt_inc      = cnt_q + CW'(1);
    obuf_valid_d = take || (obuf_valid_q && !out_ena);
    obuf_data_d  = take ? (sel ? bus.in1_first : bus.in0_first) : obuf_data_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          cnt_d       = CW'(1);
          grant_idx_d = sel;
          if (MAX_BURST == 1) last_d = sel;
          else                state_d = BURST;
        end
      end
      BURST: begin
        if (!vg) begin
          state_d = IDLE;
          last_d  = grant_idx_q;
        end else if (take) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(MAX_BURST)) begin
            state_d = IDLE;
            last_d  = grant_idx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_out2in_rr_arbiter.sv
// Directed bench for out2in_rr_arbiter: a MAX_BURST=4 instance with modelled
// FIFO sources, plus a MAX_BURST=1 instance with permanently valid sources.
module tb_out2in_rr_arbiter;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  out2in_rr_arbiter_if #(.width(32)) bus ();
  out2in_rr_arbiter_if #(.width(32)) bus1 ();

  out2in_rr_arbiter #(.width(32), .MAX_BURST(4)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
  out2in_rr_arbiter #(.width(32), .MAX_BURST(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  logic [31:0] src0 [16];
  logic [31:0] src1 [16];
  int p0, p1, n0, n1;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.in0_first      = (p0 < n0) ? src0[p0] : 32'h0;
    bus.in0_first__RDY = (p0 < n0);
    bus.in0_deq__RDY   = (p0 < n0);
    bus.in1_first      = (p1 < n1) ? src1[p1] : 32'h0;
    bus.in1_first__RDY = (p1 < n1);
    bus.in1_deq__RDY   = (p1 < n1);
  endtask

  task automatic load(input int a0, input int s0, input int c0,
                      input int a1, input int s1, input int c1);
    for (int i = 0; i < 16; i++) begin
      src0[i] = 32'(a0 + s0 * i);
      src1[i] = 32'(a1 + s1 * i);
    end
    p0 = 0; p1 = 0; n0 = c0; n1 = c1;
    drive();
    #1;
  endtask

  // Advance one clock; sources pop what the DUT dequeued at that edge.
  task automatic tick();
    logic e0, e1;
    e0 = bus.in0_deq__ENA;
    e1 = bus.in1_deq__ENA;
    @(posedge CLK);
    #1;
    if (e0) p0++;
    if (e1) p1++;
    drive();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    load(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] exp_d;
    int s, idx;
    RST = 1'b1;
    bus.out_enq__RDY = 1'b1;
    bus1.in0_first = 32'h55; bus1.in0_first__RDY = 1'b1; bus1.in0_deq__RDY = 1'b1;
    bus1.in1_first = 32'h66; bus1.in1_first__RDY = 1'b1; bus1.in1_deq__RDY = 1'b1;
    bus1.out_enq__RDY = 1'b1;

    // Reset state, with a source already valid while reset is held
    load(32'h11, 32'h11, 2, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_out_ena", 32'(bus.out_enq__ENA), 0);
    chk("rst_deq0", 32'(bus.in0_deq__ENA), 0);
    chk("rst_grant_valid", 32'(bus.grant_valid), 0);
    chk("rst_grant_idx", 32'(bus.grant_idx), 0);
    chk("rst_out_v", bus.out_enq_v, 0);
    chk("rst_dut1_deq0", 32'(bus1.in0_deq__ENA), 0);
    RST = 1'b0;
    #1;

    // Test 1: single source, two beats
    chk("t1_c0_deq0", 32'(bus.in0_deq__ENA), 1);
    chk("t1_c0_deq1", 32'(bus.in1_deq__ENA), 0);
    tick();
    chk("t1_c1_deq0", 32'(bus.in0_deq__ENA), 1);
    chk("t1_c1_out_ena", 32'(bus.out_enq__ENA), 1);
    chk("t1_c1_out_v", bus.out_enq_v, 32'h11);
    chk("t1_c1_grant_valid", 32'(bus.grant_valid), 1);
    tick();
    chk("t1_c2_deq0", 32'(bus.in0_deq__ENA), 0);
    chk("t1_c2_out_v", bus.out_enq_v, 32'h22);
    chk("t1_c2_out_ena", 32'(bus.out_enq__ENA), 1);
    tick();
    chk("t1_c3_grant_valid", 32'(bus.grant_valid), 0);
    chk("t1_c3_out_ena", 32'(bus.out_enq__ENA), 0);

    // Test 2: both valid, bursts of 4 alternate
    do_reset();
    load(32'hA0, 1, 12, 32'hB0, 1, 12);
    for (int k = 0; k <= 12; k++) begin
      if (k <= 11) begin
        chk($sformatf("t2_c%0d_deq0", k), 32'(bus.in0_deq__ENA), 32'(((k / 4) % 2) == 0));
        chk($sformatf("t2_c%0d_deq1", k), 32'(bus.in1_deq__ENA), 32'(((k / 4) % 2) == 1));
      end
      if (k >= 1) begin
        s     = ((k - 1) / 4) % 2;
        idx   = ((k - 1) / 8) * 4 + ((k - 1) % 4);
        exp_d = s ? 32'(32'hB0 + idx) : 32'(32'hA0 + idx);
        chk($sformatf("t2_c%0d_out_v", k), bus.out_enq_v, exp_d);
        chk($sformatf("t2_c%0d_grant_idx", k), 32'(bus.grant_idx), 32'(s));
      end
      tick();
    end

    // Test 3: in0 runs dry mid-burst, in1 served on the following cycle
    do_reset();
    load(32'hC0, 1, 2, 32'hD0, 1, 4);
    chk("t3_c0_deq0", 32'(bus.in0_deq__ENA), 1);
    tick();
    chk("t3_c1_deq0", 32'(bus.in0_deq__ENA), 1);
    chk("t3_c1_out_v", bus.out_enq_v, 32'hC0);
    tick();
    chk("t3_c2_deq0", 32'(bus.in0_deq__ENA), 0);
    chk("t3_c2_deq1", 32'(bus.in1_deq__ENA), 0);
    chk("t3_c2_out_v", bus.out_enq_v, 32'hC1);
    tick();
    chk("t3_c3_deq1", 32'(bus.in1_deq__ENA), 1);
    chk("t3_c3_out_ena", 32'(bus.out_enq__ENA), 0);
    chk("t3_c3_grant_valid", 32'(bus.grant_valid), 0);
    tick();
    chk("t3_c4_out_v", bus.out_enq_v, 32'hD0);
    chk("t3_c4_grant_idx", 32'(bus.grant_idx), 1);

    // Test 4: sink stalls for 3 cycles with the buffer full
    do_reset();
    load(32'hE0, 1, 6, 32'hF0, 1, 4);
    chk("t4_c0_deq0", 32'(bus.in0_deq__ENA), 1);
    tick();
    chk("t4_c1_deq0", 32'(bus.in0_deq__ENA), 1);
    chk("t4_c1_out_v", bus.out_enq_v, 32'hE0);
    tick();
    bus.out_enq__RDY = 1'b0;
    #1;
    for (int k = 2; k <= 4; k++) begin
      chk($sformatf("t4_c%0d_deq0", k), 32'(bus.in0_deq__ENA), 0);
      chk($sformatf("t4_c%0d_deq1", k), 32'(bus.in1_deq__ENA), 0);
      chk($sformatf("t4_c%0d_out_ena", k), 32'(bus.out_enq__ENA), 0);
      chk($sformatf("t4_c%0d_out_v", k), bus.out_enq_v, 32'hE1);
      tick();
    end
    bus.out_enq__RDY = 1'b1;
    #1;
    chk("t4_c5_out_ena", 32'(bus.out_enq__ENA), 1);
    chk("t4_c5_out_v", bus.out_enq_v, 32'hE1);
    chk("t4_c5_deq0", 32'(bus.in0_deq__ENA), 1);
    tick();
    chk("t4_c6_out_v", bus.out_enq_v, 32'hE2);
    chk("t4_c6_deq0", 32'(bus.in0_deq__ENA), 1);
    tick();
    chk("t4_c7_deq1", 32'(bus.in1_deq__ENA), 1);
    chk("t4_c7_deq0", 32'(bus.in0_deq__ENA), 0);
    chk("t4_c7_out_v", bus.out_enq_v, 32'hE3);
    chk("t4_c7_grant_valid", 32'(bus.grant_valid), 0);

    // Test 5: reset in the middle of a burst
    do_reset();
    load(32'h30, 1, 4, 32'h40, 1, 4);
    chk("t5_c0_deq0", 32'(bus.in0_deq__ENA), 1);
    tick();
    chk("t5_c1_deq0", 32'(bus.in0_deq__ENA), 1);
    RST = 1'b1;
    #1;
    chk("t5_rst_deq0", 32'(bus.in0_deq__ENA), 0);
    chk("t5_rst_deq1", 32'(bus.in1_deq__ENA), 0);
    chk("t5_rst_out_ena", 32'(bus.out_enq__ENA), 0);
    chk("t5_rst_grant_valid", 32'(bus.grant_valid), 0);
    tick();
    chk("t5_rst_hold_deq0", 32'(bus.in0_deq__ENA), 0);
    RST = 1'b0;
    #1;
    chk("t5_rel_deq0", 32'(bus.in0_deq__ENA), 1);
    chk("t5_rel_deq1", 32'(bus.in1_deq__ENA), 0);
    tick();
    chk("t5_rel_out_v", bus.out_enq_v, 32'h31);

    // Test 6: MAX_BURST=1 instance alternates every cycle
    do_reset();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t6_c%0d_deq0", k), 32'(bus1.in0_deq__ENA), 32'((k % 2) == 0));
      chk($sformatf("t6_c%0d_deq1", k), 32'(bus1.in1_deq__ENA), 32'((k % 2) == 1));
      chk($sformatf("t6_c%0d_grant_valid", k), 32'(bus1.grant_valid), 0);
      if (k >= 1) begin
        chk($sformatf("t6_c%0d_out_ena", k), 32'(bus1.out_enq__ENA), 1);
        chk($sformatf("t6_c%0d_out_v", k), bus1.out_enq_v, ((k % 2) == 1) ? 32'h55 : 32'h66);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
